// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word-aligned fetches, buffers in-order responses
// in a small FIFO for decode, and handles redirects and access-fault stops.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          MAX_OUT    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_fault,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic {ST_RUN, ST_STOP} state_t;

    localparam int CW = 8;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic            active_q, active_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      wr_q, wr_d;
    logic [1:0]      rd_q, rd_d;

    logic [31:0]     data_q  [4];
    logic [31:0]     epc_q   [4];
    logic            fault_q [4];

    logic [CW-1:0]   live;
    logic [CW-1:0]   occ;
    logic            pop;
    logic            req_fire;
    logic            rsp_hit;
    logic            rsp_drop;
    logic            push;
    logic            unused_low_bits;

    assign unused_low_bits = ^redirect_pc[1:0];

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        if (p == 2'(FIFO_DEPTH - 1)) return 2'd0;
        return p + 2'd1;
    endfunction

    assign instr_valid = (cnt_q != '0);
    assign pop         = instr_valid && instr_ready;
    assign live        = out_q - drop_q;
    // A pop this cycle frees a slot, so fetch can keep one request per cycle in flight.
    assign occ         = cnt_q + live - CW'(pop);

    assign imem_req_valid = active_q && (state_q == ST_RUN) &&
                            (out_q < CW'(MAX_OUT)) && (occ < CW'(FIFO_DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_hit  = imem_rsp_valid && (out_q != '0);
    assign rsp_drop = (drop_q != '0) || redirect_valid || (state_q == ST_STOP);
    assign push     = rsp_hit && !rsp_drop;

    always_comb begin
        active_d = 1'b1;
        pc_d     = pc_q;
        state_d  = state_q;
        out_d    = out_q + CW'(req_fire) - CW'(rsp_hit);
        drop_d   = drop_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        wr_d     = push ? ptr_inc(wr_q) : wr_q;
        rd_d     = pop ? ptr_inc(rd_q) : rd_q;

        if (rsp_hit && (drop_q != '0)) drop_d = drop_q - 1'b1;
        if (push && imem_rsp_err) state_d = ST_STOP;
        if (req_fire) pc_d = pc_q + 32'd4;

        // Everything still in flight after this cycle belongs to the old path.
        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            state_d = ST_RUN;
            drop_d  = out_d;
            cnt_d   = '0;
            wr_d    = 2'd0;
            rd_d    = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            active_q <= 1'b0;
            out_q    <= '0;
            drop_q   <= '0;
            cnt_q    <= '0;
            wr_q     <= 2'd0;
            rd_q     <= 2'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            active_q <= active_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
        end
    end

    // Entry storage needs no reset; outputs are gated by instr_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_q]  <= imem_rsp_data;
            epc_q[wr_q]   <= pc_q - {out_q[CW-3:0] - drop_q[CW-3:0], 2'b00};
            fault_q[wr_q] <= imem_rsp_err;
        end
    end

    always_comb begin
        instr       = '0;
        instr_pc    = '0;
        instr_fault = 1'b0;
        if (instr_valid) begin
            instr       = data_q[rd_q];
            instr_pc    = epc_q[rd_q];
            instr_fault = fault_q[rd_q];
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory model, spec-level fetch-stream
// scoreboard, directed corner sequences and a randomized phase.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam int          MAXO     = 2;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    instr_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .MAX_OUT(MAXO)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .imem_rsp_err(imem_rsp_err),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_fault(instr_fault), .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct { logic [31:0] addr; logic [31:0] data; logic err; int due; } mem_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; logic fault; } ent_t;
    typedef struct { logic [31:0] rpc; logic [31:0] exp_addr; logic [31:0] exp_next; } redir_vec_t;

    mem_t        mem_q[$];
    ent_t        exp_q[$];
    redir_vec_t  vecs[4];

    int          n_checks, n_pass;
    int          cyc, last_due, lat_min, lat_max, n_pops;
    logic [31:0] model_pc, fault_addr;
    logic        fault_pushed, fault_delivered;
    logic        prev_pending, prev_hold;
    logic [31:0] prev_addr, prev_ipc, prev_instr;
    logic        prev_ifault;
    logic        rand_mode, drv_req_ready, drv_instr_ready, drv_redirect;
    logic [31:0] drv_redirect_pc;
    logic [31:0] last_pop_pc, fault_pc;
    logic        fault_seen;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic apply();
        mem_t m;
        @(posedge clk);
        #1;
        cyc++;
        imem_req_ready = rand_mode ? ($urandom_range(0, 3) != 0) : drv_req_ready;
        instr_ready    = rand_mode ? ($urandom_range(0, 2) != 0) : drv_instr_ready;
        redirect_valid = 1'b0;
        if (drv_redirect) begin
            redirect_valid = 1'b1;
            redirect_pc    = drv_redirect_pc;
            drv_redirect   = 1'b0;
        end
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            m = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = m.data;
            imem_rsp_err   = m.err;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            imem_rsp_err   = 1'b0;
        end
    endtask

    task automatic sample();
        mem_t m;
        ent_t e;
        int   due;
        @(negedge clk);
        if (prev_pending && imem_req_valid) chk("req_addr_stable", imem_req_addr, prev_addr);
        if (prev_hold) begin
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_pc", instr_pc, prev_ipc);
            chk("hold_instr", instr, prev_instr);
            chk("hold_fault", 32'(instr_fault), 32'(prev_ifault));
        end
        if (fault_delivered) chk("no_req_in_stop", 32'(imem_req_valid), 32'd0);
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, model_pc);
            due = cyc + int'($urandom_range(lat_min, lat_max));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            m.addr = imem_req_addr; m.data = mem_data(imem_req_addr);
            m.err = (imem_req_addr == fault_addr); m.due = due;
            mem_q.push_back(m);
            if (!redirect_valid && !fault_pushed) begin
                e.pc = m.addr; e.data = m.data; e.fault = m.err;
                exp_q.push_back(e);
                if (m.err) fault_pushed = 1'b1;
            end
            model_pc = model_pc + 32'd4;
        end
        if (instr_valid && instr_ready) begin
            n_pops++;
            last_pop_pc = instr_pc;
            if (instr_fault) begin fault_seen = 1'b1; fault_pc = instr_pc; end
            if (exp_q.size() == 0) begin
                chk("spurious_pop", 32'(instr_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("instr_pc", instr_pc, e.pc);
                chk("instr_data", instr, e.data);
                chk("instr_fault", 32'(instr_fault), 32'(e.fault));
                if (e.fault) fault_delivered = 1'b1;
            end
        end
        if (redirect_valid) begin
            exp_q.delete();
            model_pc        = {redirect_pc[31:2], 2'b00};
            fault_pushed    = 1'b0;
            fault_delivered = 1'b0;
        end
        prev_pending = imem_req_valid && !imem_req_ready && !redirect_valid;
        prev_addr    = imem_req_addr;
        prev_hold    = instr_valid && !instr_ready && !redirect_valid;
        prev_ipc     = instr_pc;
        prev_instr   = instr;
        prev_ifault  = instr_fault;
    endtask

    task automatic cycle();
        apply();
        sample();
    endtask

    task automatic redirect_to(input logic [31:0] t);
        drv_redirect    = 1'b1;
        drv_redirect_pc = t;
    endtask

    task automatic model_reset();
        mem_q.delete();
        exp_q.delete();
        model_pc        = RESET_PC;
        fault_pushed    = 1'b0;
        fault_delivered = 1'b0;
        prev_pending    = 1'b0;
        prev_hold       = 1'b0;
    endtask

    initial begin
        int   start, n_req;
        logic hit;
        logic [31:0] a0;

        vecs[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[2] = '{32'h1234_5671, 32'h1234_5670, 32'h1234_5674};
        vecs[3] = '{32'h0000_0040, 32'h0000_0040, 32'h0000_0044};

        n_checks = 0; n_pass = 0; cyc = 0; last_due = 0; n_pops = 0;
        lat_min = 1; lat_max = 1; fault_addr = 32'h1;
        rand_mode = 1'b0; drv_req_ready = 1'b1; drv_instr_ready = 1'b1;
        drv_redirect = 1'b0; drv_redirect_pc = '0;
        fault_seen = 1'b0; fault_pc = '0; last_pop_pc = '0;
        prev_addr = '0; prev_ipc = '0; prev_instr = '0; prev_ifault = 1'b0;
        model_reset();

        rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = '0; imem_rsp_err = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_instr_fault", 32'(instr_fault), 32'd0);

        @(posedge clk); #1;
        rst_n = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        sample();
        cycle();
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, RESET_PC);
        cycle();
        chk("latency_not_yet", 32'(instr_valid), 32'd0);
        cycle();
        chk("latency_valid", 32'(instr_valid), 32'd1);
        chk("first_instr_pc", instr_pc, RESET_PC);

        // Steady-state throughput: one instruction per cycle
        start = n_pops;
        repeat (10) cycle();
        chk("steady_throughput", 32'(n_pops - start), 32'd10);

        // Decode back-pressure
        drv_instr_ready = 1'b0;
        repeat (10) cycle();
        chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
        chk("bp_buffered", 32'(exp_q.size()), 32'(DEPTH));
        chk("bp_instr_valid", 32'(instr_valid), 32'd1);
        drv_instr_ready = 1'b1;
        repeat (6) cycle();

        // Redirect table, including low-bit masking and PC wrap
        drv_req_ready = 1'b0;
        repeat (4) cycle();
        for (int i = 0; i < 4; i++) begin
            redirect_to(vecs[i].rpc);
            cycle();
            cycle();
            chk("redir_valid", 32'(imem_req_valid), 32'd1);
            chk("redir_addr", imem_req_addr, vecs[i].exp_addr);
            drv_req_ready = 1'b1;
            cycle();
            drv_req_ready = 1'b0;
            cycle();
            chk("redir_next_addr", imem_req_addr, vecs[i].exp_next);
            repeat (4) cycle();
        end

        // Stalled request stays put, then follows a redirect
        cycle();
        a0 = imem_req_addr;
        repeat (5) begin
            cycle();
            chk("stall_addr", imem_req_addr, a0);
        end
        redirect_to(32'h0000_0300);
        cycle();
        cycle();
        chk("stall_redirect_addr", imem_req_addr, 32'h0000_0300);

        // Redirect with two requests outstanding
        lat_min = 3; lat_max = 3;
        drv_req_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (mem_q.size() >= 2) break;
        end
        chk("outstanding_before_redirect", 32'(mem_q.size()), 32'd2);
        redirect_to(32'h0000_0103);
        cycle();
        last_pop_pc = 32'hDEAD_BEEF;
        start = n_pops;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (n_pops != start) break;
        end
        chk("pc_after_drop", last_pop_pc, 32'h0000_0100);
        lat_min = 1; lat_max = 1;

        // Access fault at PC 8
        fault_addr = 32'h0000_0008;
        redirect_to(32'h0000_0000);
        cycle();
        fault_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (fault_seen) break;
        end
        chk("fault_seen", 32'(fault_seen), 32'd1);
        chk("fault_pc", fault_pc, 32'h0000_0008);
        n_req = 0;
        repeat (8) begin
            cycle();
            if (imem_req_valid) n_req++;
        end
        chk("no_req_after_fault", 32'(n_req), 32'd0);
        fault_addr = 32'h1;
        redirect_to(32'h0000_0200);
        cycle();
        cycle();
        chk("resume_valid", 32'(imem_req_valid), 32'd1);
        chk("resume_addr", imem_req_addr, 32'h0000_0200);
        repeat (6) cycle();

        // Redirect, response and pop in the same cycle
        hit = 1'b0;
        start = n_pops;
        for (int i = 0; i < 20; i++) begin
            apply();
            if (imem_rsp_valid && instr_valid) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h0000_0500;
                hit = 1'b1;
            end
            start = n_pops;
            sample();
            if (hit) break;
        end
        chk("simul_hit", 32'(hit), 32'd1);
        chk("simul_pop_done", 32'(n_pops - start), 32'd1);
        cycle();
        chk("simul_fifo_empty", 32'(instr_valid), 32'd0);
        last_pop_pc = 32'hDEAD_BEEF;
        start = n_pops;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (n_pops != start) break;
        end
        chk("simul_resume_pc", last_pop_pc, 32'h0000_0500);
        repeat (4) cycle();

        // Asynchronous reset mid-operation
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("async_rst_instr_valid", 32'(instr_valid), 32'd0);
        model_reset();
        imem_rsp_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sample();
        cycle();
        chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("post_rst_addr", imem_req_addr, RESET_PC);

        // Randomized traffic against the scoreboard
        rand_mode = 1'b1;
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                a0 = 32'h0000_1000 + (32'($urandom_range(0, 255)) << 2) + 32'($urandom_range(0, 3));
                redirect_to(a0);
                fault_addr = ($urandom_range(0, 1) == 1) ?
                             ({a0[31:2], 2'b00} + (32'($urandom_range(0, 5)) << 2)) : 32'h1;
            end
            cycle();
        end

        // Drain
        rand_mode = 1'b0;
        drv_req_ready = 1'b0;
        drv_instr_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (exp_q.size() == 0 && mem_q.size() == 0) break;
        end
        cycle();
        chk("drain_exp_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_instr_valid", 32'(instr_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 2, the instruction buffer depth (legal values 2..4).
REQ-003 The block SHALL have parameter MAX_OUT, default 2, the maximum number of outstanding memory requests.
REQ-004 The block SHALL use one clock; reset SHALL be asynchronous and active-low. Ports:
 clk  in  1  rising-edge clock
 rst_n  in  1  asynchronous active-low reset
 imem_req_valid  out  1  fetch request valid
 imem_req_addr  out  32  word-aligned fetch address
 imem_req_ready  in  1  memory accepts request
 imem_rsp_valid  in  1  response valid (no back-pressure, in order)
 imem_rsp_data  in  32  fetched instruction word
 imem_rsp_err  in  1  access fault on this response
 instr_valid  out  1  instruction available to decode
 instr  out  32  instruction word to decode
 instr_pc  out  32  PC of instr
 instr_fault  out  1  instr carries an access fault
 instr_ready  in  1  decode accepts instruction
 redirect_valid  in  1  branch/jump/trap redirect
 redirect_pc  in  32  redirect target

Function
REQ-005 Request handshake SHALL occur on the cycle imem_req_valid and imem_req_ready are both 1; the fetch PC SHALL then advance by 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-006 While a request is valid and not accepted, imem_req_addr SHALL remain stable unless a redirect occurs.
REQ-007 A request SHALL be issued only if outstanding < MAX_OUT and fifo_count + live_outstanding < FIFO_DEPTH, so each response always has a buffer slot.
REQ-008 Every imem_rsp_valid cycle SHALL either be written to the FIFO (data, PC, fault) or dropped, per REQ-011; responses SHALL be buffered in issue order.
REQ-009 instr_valid SHALL assert the cycle after a response is written (no bypass); minimum request-to-instr_valid latency is 2 cycles with a 1-cycle memory.
REQ-010 FIFO pop SHALL occur when instr_valid and instr_ready are both 1; instr, instr_pc, instr_fault SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-011 On redirect_valid=1: fetch PC <= {redirect_pc[31:2],2'b00} (low bits ignored); FIFO flushed next cycle; every outstanding request, including one accepted in that same cycle, SHALL be counted in a drop counter, and its response discarded.
REQ-012 Redirect SHALL have priority over PC increment; a pop in the redirect cycle SHALL complete normally; a response arriving in the redirect cycle SHALL be dropped.
REQ-013 A pending unaccepted request SHALL be retargeted to the redirect address on the next cycle.
REQ-014 State machine: RUN (issuing) and STOP; RUN -> STOP when a response with imem_rsp_err=1 is written; STOP issues no requests; STOP -> RUN only on redirect_valid.
REQ-015 In STOP, earlier buffered entries SHALL still drain in order, followed by the faulting entry with instr_fault=1; later non-dropped responses SHALL be discarded.
REQ-016 Outstanding and drop counters SHALL never underflow or exceed MAX_OUT; FIFO SHALL never overflow (REQ-007) nor pop when empty.

Reset
REQ-017 While rst_n=0: imem_req_valid=0, instr_valid=0, instr_fault=0, instr=0, instr_pc=0, fetch PC=RESET_PC, counters=0, FIFO empty, state RUN.
REQ-018 First rising edge after deassertion SHALL drive imem_req_valid=1, imem_req_addr=RESET_PC.
REQ-019 Reset asserted mid-operation SHALL clear all state immediately; responses to pre-reset requests are the memory's responsibility to suppress.

Verification
REQ-020 Reset release, memory ready always, 1-cycle response, instr_ready=1 -> instr_pc sequence 0,4,8,... one per cycle at steady state.
REQ-021 instr_ready=0 for 10 cycles -> at most FIFO_DEPTH entries buffered, imem_req_valid=0 once full, no data lost, order kept on release.
REQ-022 Redirect to 32'h0000_0103 with 2 requests outstanding -> both responses dropped, next instr_pc=32'h0000_0100.
REQ-023 Response for PC 8 with imem_rsp_err=1 -> instr_fault=1 at instr_pc=8, no further requests until redirect, then fetch resumes at target.
REQ-024 imem_req_ready=0 for 5 cycles -> imem_req_addr stable; redirect during stall -> address changes to target next cycle.
REQ-025 Simultaneous redirect, response and pop in one cycle -> popped entry consumed, response dropped, FIFO empty next cycle, no counter underflow.
